// File: rtl/tron_pkg.sv
// Shared constants for the Tron frame-buffer datapath: colour codes,
// screen geometry and the trail writer's state encoding.
package tron_pkg;

    localparam logic [3:0] COLOR_BG      = 4'h0;
    localparam logic [3:0] COLOR_BLUE    = 4'h1;
    localparam logic [3:0] COLOR_RED     = 4'h2;
    localparam logic [3:0] COLOR_BIKE    = 4'hf;
    localparam logic [3:0] COLOR_BLOCKED = 4'h7;

    localparam int SCREEN_W       = 640;
    localparam int SCREEN_H       = 480;
    localparam int WORDS_PER_LINE = 320;
    localparam int FB_WORDS       = 153600;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t CLEAR = 2'd1;
    localparam state_t BLUE  = 2'd2;
    localparam state_t RED   = 2'd3;

endpackage

// File: rtl/fb_addr_calc.sv
// Pixel (x,y) to frame-buffer word address; two pixels per word, 320 words per line.
// Shared by the trail writer and the compositor.
module fb_addr_calc (
    input  logic [9:0]  x_i,
    input  logic [9:0]  y_i,
    output logic [18:0] addr_o
);

    // y*320 split as y*256 + y*64 so no multiplier is needed.
    assign addr_o = 19'(x_i >> 1) + (19'(y_i) << 8) + (19'(y_i) << 6);

endmodule

// File: rtl/trail_writer.sv
// Write-side master of the frame buffer: full-screen clear after reset or on
// request, then per-frame stamping of each live bike's trail rows.
module trail_writer
    import tron_pkg::*;
#(
    parameter int         TRAIL_H    = 2,
    parameter logic [3:0] BG_COLOR   = COLOR_BG,
    parameter logic [3:0] BLUE_COLOR = COLOR_BLUE,
    parameter logic [3:0] RED_COLOR  = COLOR_RED
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        clear_req,
    input  logic [9:0]  Blue_X_real,
    input  logic [9:0]  Blue_Y_real,
    input  logic [9:0]  Red_X_real,
    input  logic [9:0]  Red_Y_real,
    input  logic        blue_alive,
    input  logic        red_alive,
    output logic        WE,
    output logic [18:0] write_address,
    output logic [15:0] Data_Out,
    output logic        busy,
    output logic        clear_done
);

    state_t      state_q, state_d;
    logic [18:0] cnt_q, cnt_d;
    logic [3:0]  row_q, row_d;
    logic        pend_q, pend_d;
    logic        fc_q;
    logic [9:0]  bx_q, by_q, rx_q, ry_q;
    logic        bv_q, rv_q;
    logic        latch_en;

    logic        we_q, we_d;
    logic [18:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        frame_edge;
    logic        blue_ok_in, red_ok_in;
    logic [9:0]  cur_x, cur_y;
    logic        cur_v;
    logic [3:0]  cur_c;
    logic [10:0] y_row, y_next;
    logic        row_ok, next_ok, last_row;
    logic [18:0] stamp_addr;
    state_t      next_pass;

    assign frame_edge = frame_clk & ~fc_q;
    assign blue_ok_in = blue_alive && (Blue_X_real < 10'(SCREEN_W)) && (Blue_Y_real < 10'(SCREEN_H));
    assign red_ok_in  = red_alive  && (Red_X_real  < 10'(SCREEN_W)) && (Red_Y_real  < 10'(SCREEN_H));

    assign cur_x     = (state_q == RED) ? rx_q : bx_q;
    assign cur_y     = (state_q == RED) ? ry_q : by_q;
    assign cur_v     = (state_q == RED) ? rv_q : bv_q;
    assign cur_c     = (state_q == RED) ? RED_COLOR : BLUE_COLOR;
    assign next_pass = (state_q == BLUE) ? RED : IDLE;

    // Rows run top-down, so once one falls off the bottom every later row does too.
    assign y_row    = {1'b0, cur_y} + {7'b0, row_q};
    assign y_next   = y_row + 11'd1;
    assign row_ok   = y_row < 11'(SCREEN_H);
    assign next_ok  = y_next < 11'(SCREEN_H);
    assign last_row = (row_q == 4'(TRAIL_H - 1));

    fb_addr_calc u_addr (
        .x_i    (cur_x),
        .y_i    (y_row[9:0]),
        .addr_o (stamp_addr)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        row_d    = row_q;
        pend_d   = pend_q | clear_req;
        latch_en = 1'b0;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_q || clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end else if (frame_edge) begin
                    state_d  = BLUE;
                    row_d    = '0;
                    latch_en = 1'b1;
                end
            end
            CLEAR: begin
                busy_d = 1'b1;
                pend_d = 1'b0;
                // A fresh request mid-clear restarts the sweep at word 0.
                if (clear_req) begin
                    we_d   = 1'b1;
                    addr_d = '0;
                    data_d = {4'h0, BG_COLOR, 4'h0, BG_COLOR};
                    cnt_d  = 19'd1;
                end else if (cnt_q == 19'(FB_WORDS)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    we_d   = 1'b1;
                    addr_d = cnt_q;
                    data_d = {4'h0, BG_COLOR, 4'h0, BG_COLOR};
                    cnt_d  = cnt_q + 19'd1;
                end
            end
            BLUE, RED: begin
                busy_d = 1'b1;
                if (cur_v && row_ok) begin
                    we_d   = 1'b1;
                    addr_d = stamp_addr;
                    data_d = {4'h0, cur_c, 4'h0, cur_c};
                    if (last_row || !next_ok) begin
                        state_d = next_pass;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + 4'd1;
                    end
                end else begin
                    state_d = next_pass;
                    row_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            row_q   <= '0;
            pend_q  <= 1'b0;
            fc_q    <= 1'b0;
            bx_q    <= '0;
            by_q    <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
            bv_q    <= 1'b0;
            rv_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            pend_q  <= pend_d;
            fc_q    <= frame_clk;
            if (latch_en) begin
                bx_q <= Blue_X_real;
                by_q <= Blue_Y_real;
                rx_q <= Red_X_real;
                ry_q <= Red_Y_real;
                bv_q <= blue_ok_in;
                rv_q <= red_ok_in;
            end
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign WE            = we_q;
    assign write_address = addr_q;
    assign Data_Out      = data_q;
    assign busy          = busy_q;
    assign clear_done    = done_q;

endmodule

// File: tb/tb_trail_writer.sv
// Bench for trail_writer: a queue of expected frame-buffer writes is built from
// screen geometry and checked against every write the DUT makes.
module tb_trail_writer;
    import tron_pkg::*;

    localparam int TH = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic        clear_req;
    logic [9:0]  Blue_X_real, Blue_Y_real, Red_X_real, Red_Y_real;
    logic        blue_alive, red_alive;
    logic        WE;
    logic [18:0] write_address;
    logic [15:0] Data_Out;
    logic        busy;
    logic        clear_done;

    always #5 Clk = ~Clk;

    trail_writer #(.TRAIL_H(TH)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_clk     (frame_clk),
        .clear_req     (clear_req),
        .Blue_X_real   (Blue_X_real),
        .Blue_Y_real   (Blue_Y_real),
        .Red_X_real    (Red_X_real),
        .Red_Y_real    (Red_Y_real),
        .blue_alive    (blue_alive),
        .red_alive     (red_alive),
        .WE            (WE),
        .write_address (write_address),
        .Data_Out      (Data_Out),
        .busy          (busy),
        .clear_done    (clear_done)
    );

    typedef struct packed {
        logic [18:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t expQ[$];
    wr_t logQ[$];
    int  checks = 0;
    int  failures = 0;
    int  doneCount = 0;

    function automatic void pushClear();
        wr_t w;
        for (int a = 0; a < 640 * 480 / 2; a++) begin
            w.addr = 19'(a);
            w.data = 16'h0000;
            expQ.push_back(w);
        end
    endfunction

    function automatic void pushBike(input int x, input int y, input logic alive, input logic [3:0] c);
        wr_t w;
        if (!alive || x >= 640 || y >= 480) return;
        for (int r = 0; r < TH; r++) begin
            if (y + r < 480) begin
                w.addr = 19'((x / 2) + (y + r) * 320);
                w.data = {4'h0, c, 4'h0, c};
                expQ.push_back(w);
            end
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkLog(input string name, input int idx, input int addr, input int data);
        checks++;
        if (idx >= logQ.size()) begin
            failures++;
            $display("[TB] FAIL %s: write #%0d missing (only %0d logged)", name, idx, logQ.size());
        end else if (logQ[idx].addr !== 19'(addr) || logQ[idx].data !== 16'(data)) begin
            failures++;
            $display("[TB] FAIL %s: got addr %0d data %h, expected addr %0d data %h",
                     name, logQ[idx].addr, logQ[idx].data, addr, 16'(data));
        end
    endtask

    // Every write must be the next one the model predicts, and only while busy.
    always @(negedge Clk) begin
        if (!Reset) begin
            if (WE) begin
                wr_t got;
                got.addr = write_address;
                got.data = Data_Out;
                logQ.push_back(got);
                checks++;
                if (expQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpectedWrite: got addr %0d data %h, expected no write", write_address, Data_Out);
                end else begin
                    wr_t e;
                    e = expQ.pop_front();
                    if (got !== e) begin
                        failures++;
                        $display("[TB] FAIL writeSeq: got addr %0d data %h, expected addr %0d data %h",
                                 got.addr, got.data, e.addr, e.data);
                    end
                end
                checks++;
                if (!busy) begin
                    failures++;
                    $display("[TB] FAIL busyDuringWrite: got busy 0, expected 1");
                end
            end
            if (clear_done) begin
                doneCount++;
                checks++;
                if (WE) begin
                    failures++;
                    $display("[TB] FAIL weOnDone: got WE 1, expected 0");
                end
            end
        end
    end

    task automatic waitIdle(input string name, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            #1;
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        checkOutput(name, 32'(ok), 32'd1);
    endtask

    task automatic waitDone(input string name, input int budget);
        int start = doneCount;
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            #1;
            if (doneCount > start) begin
                ok = 1;
                break;
            end
        end
        checkOutput(name, 32'(ok), 32'd1);
    endtask

    // Present bike positions, raise frame_clk and pin the two-cycle write latency.
    task automatic applyStimulus(input int bx, input int by, input logic ba,
                                 input int rx, input int ry, input logic ra,
                                 input logic pulseClear);
        @(negedge Clk);
        Blue_X_real = 10'(bx);
        Blue_Y_real = 10'(by);
        blue_alive  = ba;
        Red_X_real  = 10'(rx);
        Red_Y_real  = 10'(ry);
        red_alive   = ra;
        logQ.delete();
        pushBike(bx, by, ba, COLOR_BLUE);
        pushBike(rx, ry, ra, COLOR_RED);
        if (pulseClear) pushClear();
        frame_clk = 1'b1;
        @(posedge Clk);
        #1;
        checkOutput("weBeforeLatency", 32'(WE), 32'd0);
        @(posedge Clk);
        #1;
        checkOutput("weAtLatency", 32'(WE), 32'd1);
        if (pulseClear) clear_req = 1'b1;
        @(posedge Clk);
        #1;
        clear_req = 1'b0;
        frame_clk = 1'b0;
    endtask

    initial begin
        bit hit;
        Reset       = 1'b1;
        frame_clk   = 1'b0;
        clear_req   = 1'b0;
        Blue_X_real = '0;
        Blue_Y_real = '0;
        Red_X_real  = '0;
        Red_Y_real  = '0;
        blue_alive  = 1'b0;
        red_alive   = 1'b0;

        repeat (3) @(posedge Clk);
        #1;
        checkOutput("resetWE", 32'(WE), 32'd0);
        checkOutput("resetAddr", 32'(write_address), 32'd0);
        checkOutput("resetData", 32'(Data_Out), 32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetDone", 32'(clear_done), 32'd0);

        @(negedge Clk);
        pushClear();
        Reset = 1'b0;
        @(negedge Clk);
        checkOutput("clearFirstWe", 32'(WE), 32'd1);
        checkOutput("clearFirstAddr", 32'(write_address), 32'd0);

        // Frame tick while clearing must be dropped.
        repeat (1000) @(negedge Clk);
        Blue_X_real = 10'd100;
        Blue_Y_real = 10'd50;
        blue_alive  = 1'b1;
        frame_clk   = 1'b1;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;

        hit = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge Clk);
            #1;
            if (WE && write_address == 19'd5000) begin
                hit = 1;
                break;
            end
        end
        checkOutput("reachAddr5000", 32'(hit), 32'd1);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        checkOutput("abortWE", 32'(WE), 32'd0);
        checkOutput("abortBusy", 32'(busy), 32'd0);
        @(negedge Clk);
        expQ.delete();
        pushClear();
        Reset = 1'b0;
        @(negedge Clk);
        checkOutput("restartWe", 32'(WE), 32'd1);
        checkOutput("restartAddr", 32'(write_address), 32'd0);

        waitDone("clearDoneTimeout", 160000);
        checkOutput("clearDrained", 32'(expQ.size()), 32'd0);
        checkOutput("donePulses", 32'(doneCount), 32'd1);
        @(negedge Clk);
        checkOutput("doneOneCycle", 32'(clear_done), 32'd0);
        checkOutput("busyAfterClear", 32'(busy), 32'd0);
        repeat (10) @(negedge Clk);
        checkOutput("idleNoWe", 32'(WE), 32'd0);

        applyStimulus(100, 50, 1'b1, 641, 10, 1'b1, 1'b0);
        waitIdle("stamp1Timeout", 40);
        checkOutput("stamp1Drained", 32'(expQ.size()), 32'd0);
        checkOutput("stamp1Count", 32'(logQ.size()), 32'd2);
        checkLog("stamp1Row0", 0, 16050, 16'h0101);
        checkLog("stamp1Row1", 1, 16370, 16'h0101);

        applyStimulus(0, 479, 1'b1, 639, 0, 1'b1, 1'b0);
        waitIdle("stamp2Timeout", 40);
        checkOutput("stamp2Drained", 32'(expQ.size()), 32'd0);
        checkOutput("stamp2Count", 32'(logQ.size()), 32'd3);
        checkLog("stamp2Blue", 0, 153280, 16'h0101);
        checkLog("stamp2Red0", 1, 319, 16'h0202);
        checkLog("stamp2Red1", 2, 639, 16'h0202);

        applyStimulus(20, 20, 1'b1, 20, 20, 1'b1, 1'b0);
        waitIdle("stamp3Timeout", 40);
        checkOutput("stamp3Drained", 32'(expQ.size()), 32'd0);
        checkLog("stamp3Blue0", 0, 6410, 16'h0101);
        checkLog("stamp3Blue1", 1, 6730, 16'h0101);
        checkLog("stamp3Red0", 2, 6410, 16'h0202);
        checkLog("stamp3Red1", 3, 6730, 16'h0202);

        // Clear request lands on the first blue write: pass finishes, then clear from 0.
        applyStimulus(100, 50, 1'b1, 200, 100, 1'b1, 1'b1);
        repeat (300) @(negedge Clk);
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (1000) @(negedge Clk);
        checkLog("reqBlue0", 0, 16050, 16'h0101);
        checkLog("reqBlue1", 1, 16370, 16'h0101);
        checkLog("reqRed0", 2, 32100, 16'h0202);
        checkLog("reqRed1", 3, 32420, 16'h0202);
        checkLog("reqClearStart", 4, 0, 16'h0000);
        checkOutput("reqClearBusy", 32'(busy), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #(10 * 400000);
        failures++;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trail_writer.md
Name: trail_writer

Overview:
- Write-side master of the shared frameRAM frame buffer.
- After reset or on request, it clears the whole 640x480 buffer to the background colour.
- On every frame tick it stamps each live bike's trail segment at the bike's current position into the buffer.
- It drives the buffer's write port (write address, data, write enable); the compositor owns the read port.

Parameters:
- TRAIL_H, 2, rows stamped per bike per frame (1..8).
- BG_COLOR, 4'h0, colour enum written by clear.
- BLUE_COLOR, 4'h1, blue trail colour enum.
- RED_COLOR, 4'h2, red trail colour enum.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_clk  in  1  frame tick (~60Hz, level); rising edge triggers a stamp pass.
- clear_req  in  1  one-cycle request to re-clear the buffer (new round).
- Blue_X_real, Blue_Y_real  in  10 each  blue bike pixel position.
- Red_X_real, Red_Y_real  in  10 each  red bike pixel position.
- blue_alive, red_alive  in  1 each  stamp that bike only when high.
- WE  out  1  frame buffer write enable.
- write_address  out  19  frame buffer word address.
- Data_Out  out  16  write word.
- busy  out  1  high while in CLEAR, BLUE or RED.
- clear_done  out  1  one-cycle pulse when a clear completes.

Behaviour:
- Interface: one clock Clk. Reset is synchronous and active-high.
- All outputs are registered.
- Reset values: WE=0, write_address=0, Data_Out=0, busy=0, clear_done=0. Internal state goes to CLEAR with clear counter 0; frame_clk history register is cleared.
- Word format: one word holds two horizontally adjacent pixels, {4'h0, c_odd, 4'h0, c_even}. Every write fills both nibbles with the same colour, so the trail is 2 px wide and aligned to even X.
- Address: addr = (X>>1) + Y*320, computed as (X>>1) + (Y<<8) + (Y<<6), 19-bit result.
- Frame edge: fc_q <= frame_clk; edge = frame_clk & ~fc_q.
- An edge seen in IDLE latches all six position/alive inputs and enters BLUE next cycle. The first WE is 2 Clk cycles after frame_clk is first sampled high.
- CLEAR state:
  - Writes addresses 0..153599, one per cycle, with WE=1 and Data_Out = {4'h0,BG,4'h0,BG}.
  - After the write to 153599: WE=0 and clear_done=1 for one cycle, then go to IDLE.
  - The first write happens in the first cycle after Reset falls.
- BLUE state:
  - For r = 0..TRAIL_H-1, one write per cycle to addr(Xb, Yb+r) with colour BLUE_COLOR.
  - A row is skipped (no WE, no cycle spent) if Yb+r >= 480.
  - The whole bike is skipped if Xb >= 640, Yb >= 480, or blue_alive=0.
  - Then go to RED.
- RED state: same rules using the red latched values and RED_COLOR, then go to IDLE.
- Overlap: blue is always written before red, so red wins on a shared address.
- clear_req:
  - Accepted in any state and held as pending.
  - From IDLE, pending clear takes priority over a same-cycle frame edge and enters CLEAR.
  - During BLUE/RED, the stamp pass finishes first, then CLEAR starts.
  - During CLEAR, the counter restarts from 0.
- Frame edges during CLEAR, BLUE or RED are dropped, not queued.
- Reset mid-operation aborts immediately (WE=0 in the reset cycle) and restarts the full clear.
- busy=1 exactly in CLEAR/BLUE/RED cycles. WE is never high in IDLE.

Decomposition:
- Package tron_pkg holds:
  - Colour enum constants: background 4'h0, blue 4'h1, red 4'h2, bike 4'hf, blocked 4'h7.
  - SCREEN_W=640, SCREEN_H=480, WORDS_PER_LINE=320, FB_WORDS=153600.
  - State typedef {IDLE, CLEAR, BLUE, RED}.
- One sub-module, fb_addr_calc: combinational (x,y) -> 19-bit word address using shift-add. The compositor shares the same sub-module.

Test Plan:
- Reset held for 3 cycles, then released -> 153600 consecutive WE cycles with addresses 0..153599 and Data_Out=16'h0000, then a single clear_done pulse, busy falls, and no WE afterwards.
- After clear, Blue=(100,50) alive, Red=(641,10), frame_clk rises -> exactly 2 writes: 16050 then 16370, both Data_Out=16'h0101. No red write. First WE 2 cycles after the edge.
- Blue=(0,479), Red=(639,0), both alive, edge -> writes 153280 (blue, row 480 skipped), then 319 and 639 with Data_Out=16'h0202.
- Blue and red both at (20,20), edge -> writes 6410, 6730 (16'h0101), then 6410, 6730 (16'h0202). Last write to each address is red.
- clear_req pulsed on the cycle of the first blue write -> remaining blue and red writes complete, then a full clear starts from address 0. A frame edge during the clear produces no stamp writes.
- Reset asserted midway through a clear (address 5000) -> WE=0 in the reset cycle, and the clear restarts at address 0 after release.
